// File: rtl/ucore_bus_arbiter_pkg.sv
// ucore_arb_pkg: FSM state encoding and timeout-counter sizing shared by the ucore arbiters
package ucore_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} arb_state_t;
   function automatic int cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction
endpackage

// File: rtl/ucore_bus_arbiter_if.sv
// ucore_bus_arbiter_if: ucore request/response bundles plus the system bus slave port
//   req_*     : per-requester request (packed, requester i at [i*W +: W])
//   rsp_*     : one-hot response strobe with shared data/error
//   bus_*     : single-transaction bus towards the slave
//   master    : arbiter view; slave: environment view
interface ucore_bus_arbiter_if #(parameter int NREQ = 4, parameter int AW = 32, parameter int DW = 32);
   logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]      rsp_rdata, bus_wdata, bus_rdata;
   logic [AW-1:0]      bus_addr;
   logic               rsp_error, bus_valid, bus_write, bus_ready, bus_error;
   modport master (
      input  req_valid, req_write, req_addr, req_wdata, bus_ready, bus_rdata, bus_error,
      output req_ready, rsp_valid, rsp_rdata, rsp_error, bus_valid, bus_write, bus_addr, bus_wdata
   );
   modport slave (
      output req_valid, req_write, req_addr, req_wdata, bus_ready, bus_rdata, bus_error,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error, bus_valid, bus_write, bus_addr, bus_wdata
   );
endinterface

// File: rtl/ucore_bus_arbiter_rr_picker.sv
// ucore_rr_picker: combinational round-robin pick, first set request searching upward from i_ptr
//   i_req   : request bits      i_ptr : search start index
//   o_grant : one-hot winner    o_idx : winner index    o_any : any request set
module ucore_rr_picker #(parameter int NREQ = 4, parameter int IW = 2) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);
   logic [IW-1:0] w_k;
   // Scanning from the far end lets the closest hit to i_ptr overwrite the others.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      w_k   = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         w_k = IW'((32'(i_ptr) + 32'(j)) % 32'(NREQ));
         if (i_req[w_k]) begin
            o_any = 1'b1;
            o_idx = w_k;
         end
      end
   end
   assign o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
endmodule

// File: rtl/ucore_bus_arbiter.sv
// ucore_bus_arbiter: round-robin sharing of one bus between NREQ ucores, one transaction at a time
//   clk, areset : clock and asynchronous active-high reset
//   io          : ucore request/response bundles and bus slave port (master modport)
module ucore_bus_arbiter
   import ucore_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input logic clk,
   input logic areset,
   ucore_bus_arbiter_if.master io
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = cnt_w(TIMEOUT);
   arb_state_t      r_state, w_next;
   logic [IW-1:0]   r_ptr, r_win, w_idx;
   logic [NREQ-1:0] w_grant;
   logic            w_any, w_tmo, r_err, r_write;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_rdata, r_wdata;
   logic [AW-1:0]   r_addr;

   ucore_rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
      .i_req(io.req_valid), .i_ptr(r_ptr), .o_grant(w_grant), .o_idx(w_idx), .o_any(w_any)
   );

   assign w_tmo = r_cnt == CW'(TIMEOUT);

   always_ff @(posedge clk or posedge areset)
      if (areset) r_state <= IDLE;
      else r_state <= w_next;

   // Slave completion is checked before the timeout so a late bus_ready still wins.
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE && w_any) ? BUS :
               (r_state == BUS && (io.bus_ready || w_tmo)) ? RESP :
               (r_state == RESP) ? IDLE : r_state;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_ptr   <= '0;
         r_win   <= '0;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_win   <= w_idx;
            r_ptr   <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            r_write <= io.req_write[w_idx];
            r_addr  <= io.req_addr[w_idx*AW +: AW];
            r_wdata <= io.req_wdata[w_idx*DW +: DW];
         end
         if (r_state == BUS) begin
            r_cnt <= (io.bus_ready || w_tmo) ? r_cnt : r_cnt + 1'b1;
            if (io.bus_ready) begin
               r_rdata <= r_write ? '0 : io.bus_rdata;
               r_err   <= io.bus_error;
            end else if (w_tmo) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end
         if (r_state == RESP) r_cnt <= '0;
      end
   end

   // Grant is masked during reset so every output reads 0 while areset is high.
   assign io.req_ready = (r_state == IDLE && !areset) ? w_grant : '0;
   assign io.rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_win) : '0;
   assign io.rsp_rdata = r_rdata;
   assign io.rsp_error = r_err;
   assign io.bus_valid = r_state == BUS;
   assign io.bus_write = r_write;
   assign io.bus_addr  = r_addr;
   assign io.bus_wdata = r_wdata;
endmodule

// File: tb/tb_ucore_bus_arbiter.sv
// tb_ucore_bus_arbiter: directed scoreboard bench for the round-robin bus arbiter
module tb_ucore_bus_arbiter;
   localparam int NREQ = 4, AW = 32, DW = 32, TIMEOUT = 15;
   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;
   logic        clk = 1'b0;
   logic        areset = 1'b1;
   int          n_tests = 0, n_fail = 0, n_rsp = 0;
   rsp_t        sb[$];
   logic [31:0] t_addr  [4] = '{32'h20, 32'h10, 32'h40, 32'h30};
   logic [31:0] t_wdata [4] = '{32'h1000, 32'h55, 32'h1002, 32'h1003};
   logic [3:0]  t_write = 4'b0010;

   ucore_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif ();
   ucore_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .areset(areset), .io(bif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mon();
      rsp_t e;
      if (bif.rsp_valid !== 4'b0) begin
         n_rsp++;
         if (sb.size() == 0) chk("rsp_unexpected", 64'(bif.rsp_valid), 64'd0);
         else begin
            e = sb.pop_front();
            chk("rsp_valid", 64'(bif.rsp_valid), 64'(4'b1 << e.idx));
            chk("rsp_rdata", 64'(bif.rsp_rdata), 64'(e.rdata));
            chk("rsp_error", 64'(bif.rsp_error), 64'(e.err));
         end
      end
   endtask

   task automatic samp();
      #1;
      mon();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction: k = slave wait cycles, k < 0 means the slave never answers.
   task automatic txn(input logic [3:0] vm, input int ew, input int k, input logic [31:0] rd, input logic er);
      int          nbv, n0;
      logic        tmo;
      logic [31:0] erd;
      nbv = 0;
      n0  = n_rsp;
      tmo = (k < 0) || (k > TIMEOUT);
      bif.req_valid = vm;
      samp();
      chk("req_ready", 64'(bif.req_ready), 64'(4'b1 << ew));
      chk("bus_valid_idle", 64'(bif.bus_valid), 64'd0);
      erd = (tmo || t_write[ew]) ? 32'h0 : rd;
      sb.push_back('{ew, erd, tmo ? 1'b1 : er});
      step();
      for (int c = 0; c <= TIMEOUT + 2; c++) begin
         bif.bus_ready = (c == k);
         bif.bus_rdata = rd;
         bif.bus_error = er;
         samp();
         if (bif.bus_valid !== 1'b1) break;
         nbv++;
         chk("req_ready_bus", 64'(bif.req_ready), 64'd0);
         chk("bus_write", 64'(bif.bus_write), 64'(t_write[ew]));
         chk("bus_addr", 64'(bif.bus_addr), 64'(t_addr[ew]));
         chk("bus_wdata", 64'(bif.bus_wdata), 64'(t_wdata[ew]));
         step();
      end
      bif.bus_ready = 1'b0;
      chk("bus_valid_cycles", 64'(nbv), 64'(tmo ? TIMEOUT + 1 : k + 1));
      chk("rsp_count", 64'(n_rsp - n0), 64'd1);
      step();
   endtask

   initial begin
      int n0;
      bif.req_valid = '0;
      bif.req_write = t_write;
      for (int i = 0; i < NREQ; i++) begin
         bif.req_addr[i*AW +: AW]  = t_addr[i];
         bif.req_wdata[i*DW +: DW] = t_wdata[i];
      end
      bif.bus_ready = 1'b0;
      bif.bus_rdata = '0;
      bif.bus_error = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bif.req_valid = 4'b1111;
      #1;
      chk("rst_req_ready", 64'(bif.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
      chk("rst_rsp_error", 64'(bif.rsp_error), 64'd0);
      chk("rst_bus_valid", 64'(bif.bus_valid), 64'd0);
      chk("rst_bus_write", 64'(bif.bus_write), 64'd0);
      chk("rst_bus_addr", 64'(bif.bus_addr), 64'd0);
      chk("rst_bus_wdata", 64'(bif.bus_wdata), 64'd0);
      bif.req_valid = '0;
      areset = 1'b0;
      step();
      samp();
      chk("idle_no_req", 64'(bif.req_ready), 64'd0);
      step();
      txn(4'b0100, 2, 0, 32'hDEADBEEF, 1'b0);
      txn(4'b0010, 1, 3, 32'hFFFF0000, 1'b0);
      txn(4'b1000, 3, -1, 32'h00001234, 1'b0);
      txn(4'b0001, 0, TIMEOUT, 32'h0000A5A5, 1'b1);
      bif.req_valid = '0;
      repeat (2) begin samp(); step(); end
      txn(4'b0001, 0, TIMEOUT, 32'h00000077, 1'b0);
      bif.req_valid = 4'b0100;
      samp();
      chk("req_ready_pre_rst", 64'(bif.req_ready), 64'b0100);
      step();
      bif.req_valid = '0;
      samp();
      chk("bus_valid_pre_rst", 64'(bif.bus_valid), 64'd1);
      areset = 1'b1;
      #1;
      chk("bus_valid_async_rst", 64'(bif.bus_valid), 64'd0);
      chk("bus_addr_async_rst", 64'(bif.bus_addr), 64'd0);
      n0 = n_rsp;
      repeat (2) begin step(); samp(); end
      areset = 1'b0;
      step();
      samp();
      chk("no_rsp_after_rst", 64'(n_rsp - n0), 64'd0);
      step();
      for (int n = 0; n < 8; n++) txn(4'b1111, n % 4, n % 3, 32'hC0DE0000 + 32'(n), 1'(n & 1));
      bif.req_valid = '0;
      repeat (3) begin samp(); step(); end
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ucore_bus_arbiter.md
# ucore_bus_arbiter

Shares one memory/peripheral bus between `NREQ` generated ucore FSM instances. Each ucore presents a single outstanding read or write request. The arbiter grants requesters in round-robin order, runs one bus transaction at a time with a timeout guard, and returns the response to the granted requester only. It sits between the ucore port bundles and the system bus slave.

## Interface
Parameters:
- `NREQ`, 4: number of ucore requesters (2..16).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 15: maximum cycles `bus_valid` is held without `bus_ready` before abort (1..255).

Ports:
- `clk`  in  1  global clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request strobe; held until accepted.
- `req_write`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*AW  packed addresses; requester i at `[i*AW +: AW]`.
- `req_wdata`  in  NREQ*DW  packed write data.
- `req_ready`  out  NREQ  one-hot acceptance pulse.
- `rsp_valid`  out  NREQ  one-hot, single-cycle response strobe.
- `rsp_rdata`  out  DW  shared read data; valid only with `rsp_valid`.
- `rsp_error`  out  1  bus error or timeout; valid only with `rsp_valid`.
- `bus_valid`  out  1  transaction request to the slave.
- `bus_write`, `bus_addr`, `bus_wdata`  out  1/AW/DW  registered transaction fields.
- `bus_ready`  in  1  slave completes the transaction this cycle.
- `bus_rdata`  in  DW  sampled when `bus_valid && bus_ready`.
- `bus_error`  in  1  sampled when `bus_valid && bus_ready`.

## Operation
- FSM states, in order: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is set, pick winner w, the first set bit searching upward (wrapping) from `rr_ptr`.
  - Assert `req_ready[w]` combinationally in that cycle.
  - Latch w and the request fields into the `bus_*` registers. Set `rr_ptr <= (w+1) mod NREQ`. Go to BUS.
  - With no request, stay in IDLE; all strobes stay 0.
- BUS:
  - `bus_valid = 1`; the `bus_*` fields stay stable.
  - On `bus_ready`: capture `bus_rdata` (write: capture 0) and `bus_error`, then go to RESP.
  - Otherwise increment `wait_cnt`. If `wait_cnt == TIMEOUT`: capture rdata = 0, error = 1, then go to RESP.
- RESP:
  - `rsp_valid[w] = 1` for exactly one cycle, with captured `rsp_rdata` and `rsp_error`.
  - `wait_cnt` clears. Go to IDLE.
- `req_ready` is only asserted in IDLE, so at most one transaction is ever outstanding. No back-to-back issue without returning to IDLE.
- A requester dropping `req_valid` before `req_ready` withdraws the request; this is legal. Withdrawal while in BUS has no effect on the transaction in flight.
- Reset values:
  - State IDLE, `rr_ptr` 0, `wait_cnt` 0.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_error`, `bus_valid`, `bus_write`, `bus_addr`, `bus_wdata`.

## Timing
- Zero-wait slave: request sampled in cycle 0 (IDLE, `req_ready`), `bus_valid` in cycle 1, `rsp_valid` in cycle 2. Next grant is possible in cycle 3.
- Slave with k wait cycles: `rsp_valid` arrives at cycle 2+k.
- Timeout: `bus_valid` is high for exactly TIMEOUT+1 cycles; `rsp_valid` with `rsp_error=1` follows in the next cycle.
- `bus_ready` arriving in the same cycle that `wait_cnt` hits TIMEOUT: completion wins, and `bus_error` is taken from the slave.
- All requesters active continuously: grants follow 0,1,2,…,NREQ-1,0. Every requester is served within NREQ transactions, so there is no starvation.
- `areset` asserted in any state: FSM returns to IDLE and outputs go to 0 asynchronously, including `bus_valid`. The in-flight transaction is dropped with no `rsp_valid`. The requester reissues after reset.
- `bus_ready` outside BUS is ignored.

## Structure
- Shared package `ucore_arb_pkg`:
  - state encoding constants (IDLE=0, BUS=1, RESP=2, 2-bit);
  - timeout-counter width `clog2(TIMEOUT+1)`.
- Sub-module `ucore_rr_picker`: purely combinational.
  - Inputs: `NREQ` request bits and `rr_ptr`.
  - Outputs: one-hot grant, winner index, `any` flag.
  - Reused by future ucore resource arbiters.
- Top module contains the FSM, field registers, timeout counter and response registers.

## Test plan
- Reset, then requester 2 reads 0x40 with `bus_rdata`=0xDEADBEEF and zero wait → `req_ready`=0100 in cycle 0, `bus_valid` in cycle 1, `rsp_valid`=0100 and `rsp_rdata`=0xDEADBEEF in cycle 2.
- All 4 `req_valid` held high for 8 transactions → grant order 0,1,2,3,0,1,2,3; `rsp_valid` never goes to a non-granted index.
- Slave never asserts `bus_ready`, TIMEOUT=15 → `bus_valid` high for 16 cycles, then `rsp_valid` with `rsp_error`=1 and `rsp_rdata`=0.
- `bus_ready` and `bus_error`=1 on the same cycle `wait_cnt` reaches TIMEOUT → single response with `rsp_error`=1, no duplicate response.
- Write from requester 1 (addr 0x10, data 0x55) with 3 slave wait cycles → `bus_write`=1 with stable `bus_addr`/`bus_wdata` over 4 cycles, `rsp_valid`=0010 at cycle 5.
- `areset` pulsed while in BUS → `bus_valid` drops immediately, no `rsp_valid`; a new request after release is granted to requester 0 first.
